// File: rtl/rf_dump.sv
// rf_dump: halts the core and streams a contiguous range of the register file
// out over a valid/ready interface, one word per READ+SEND pair.
//
// The range runs first..last inclusive and wraps from 31 back to 0 when first
// is above last. halt_req stays high for the whole dump so that the core
// cannot write the register file while it is being read.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   i_start       one-cycle dump request, honoured only when idle
//   i_abort       terminate the dump in progress (ignored when idle)
//   i_first_addr  first register index, sampled with i_start
//   i_last_addr   final register index, sampled with i_start
//   o_rf_addr     combinational register-file read address (0 when idle)
//   i_rf_data     register-file read data for o_rf_addr
//   o_halt_req    stall request to the core
//   o_out_valid   stream word valid
//   i_out_ready   stream sink ready
//   o_out_data    dumped register value
//   o_out_addr    index of the register in o_out_data
//   o_out_last    final word of the dump
//   o_busy        high whenever not idle
//   o_done        one-cycle pulse on normal completion
module rf_dump #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [AW-1:0]     i_first_addr,
    input  logic [AW-1:0]     i_last_addr,
    output logic [AW-1:0]     o_rf_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic              o_halt_req,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [AW-1:0]     o_out_addr,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StRead,
        StSend,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [AW-1:0]       r_ptr;
    logic [AW-1:0]       r_end;
    logic [DATA_W-1:0]   r_out_data;
    logic [AW-1:0]       r_out_addr;
    logic                r_out_last;
    logic                w_accept;
    logic                w_handshake;

    // start together with abort is dropped, not half-accepted
    assign w_accept    = (r_state == StIdle) && i_start && !i_abort;
    assign w_handshake = (r_state == StSend) && i_out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_next = StHalt;
            // one settling cycle so a write already in flight lands before the first read
            StHalt: w_state_next = StRead;
            StRead: w_state_next = StSend;
            StSend: begin
                if (w_handshake) begin
                    w_state_next = r_out_last ? StDone : StRead;
                end
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        // abort beats everything, including a handshake in the same cycle
        if (i_abort && (r_state != StIdle)) begin
            w_state_next = StIdle;
        end
    end

    // Datapath: range pointers and the held output word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_end      <= '0;
            r_out_data <= '0;
            r_out_addr <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr <= i_first_addr;
                r_end <= i_last_addr;
            end
            if (r_state == StRead) begin
                r_out_data <= i_rf_data;
                r_out_addr <= r_ptr;
                r_out_last <= (r_ptr == r_end);
            end
            // natural AW-bit overflow gives the 31 -> 0 wrap
            if (w_handshake && !r_out_last && !i_abort) begin
                r_ptr <= r_ptr + AW'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        o_rf_addr   = (r_state == StIdle) ? '0 : r_ptr;
        o_halt_req  = (r_state != StIdle);
        o_busy      = (r_state != StIdle);
        o_out_valid = (r_state == StSend);
        o_done      = (r_state == StDone);
        o_out_data  = r_out_data;
        o_out_addr  = r_out_addr;
        o_out_last  = r_out_last;
    end

endmodule

// File: tb/tb_rf_dump.sv
// tb_rf_dump: self-checking bench for rf_dump.
// A register-file model feeds rf_data combinationally. Expected words are pushed
// to a scoreboard queue when a dump is started and popped by a monitor on every
// handshake. A table of dumps is run in a loop, followed by hand-written
// sequences for stall, abort, reset and write-before-halt cases.
module tb_rf_dump;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_abort;
    logic [4:0]  i_first_addr;
    logic [4:0]  i_last_addr;
    logic [4:0]  o_rf_addr;
    logic [31:0] i_rf_data;
    logic        o_halt_req;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_out_data;
    logic [4:0]  o_out_addr;
    logic        o_out_last;
    logic        o_busy;
    logic        o_done;

    logic [31:0] regs [32];
    assign i_rf_data = regs[o_rf_addr];

    rf_dump #(
        .DATA_W(32),
        .AW    (5)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_first_addr(i_first_addr),
        .i_last_addr (i_last_addr),
        .o_rf_addr   (o_rf_addr),
        .i_rf_data   (i_rf_data),
        .o_halt_req  (o_halt_req),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_addr  (o_out_addr),
        .o_out_last  (o_out_last),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         n;     // expected word count
        bit         full;  // out_ready held high (else random)
        bit         poke;  // fire a stray start while busy
    } vec_t;

    exp_t sb[$];
    int   tests   = 0;
    int   fails   = 0;
    int   n_words = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per handshake, checks stall stability
    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic [4:0]  hold_a;
    logic        hold_l;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (o_out_valid && hold_v) begin
                check("stall_data_stable", o_out_data, hold_d);
                check("stall_addr_stable", {27'd0, o_out_addr}, {27'd0, hold_a});
                check("stall_last_stable", {31'd0, o_out_last}, {31'd0, hold_l});
            end
            if (o_out_valid && i_out_ready) begin
                n_words++;
                hold_v = 1'b0;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got word addr %0d, expected none", o_out_addr);
                end else begin
                    e = sb.pop_front();
                    check("word_addr", {27'd0, o_out_addr}, {27'd0, e.addr});
                    check("word_data", o_out_data, e.data);
                    check("word_last", {31'd0, o_out_last}, {31'd0, e.last});
                end
            end else if (o_out_valid) begin
                hold_v = 1'b1;
                hold_d = o_out_data;
                hold_a = o_out_addr;
                hold_l = o_out_last;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [4:0] first, input logic [4:0] last);
        logic [4:0] a;
        exp_t e;
        a = first;
        forever begin
            e.addr = a;
            e.data = regs[a];
            e.last = (a == last);
            sb.push_back(e);
            if (a == last) break;
            a = a + 5'd1;
        end
    endtask

    task automatic start_dump(input logic [4:0] first, input logic [4:0] last);
        i_first_addr = first;
        i_last_addr  = last;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    // Called right after the start edge (cycle 1 = HALT); runs to the done pulse.
    task automatic wait_done(input int n, input bit full, input bit poke);
        int c;
        int done_c;
        int first_v;
        int w0;
        bit seen;
        c       = 1;
        done_c  = -1;
        first_v = -1;
        seen    = 1'b0;
        w0      = n_words;
        while (!seen && c < 400) begin
            @(negedge clk);
            if (c == 1) check("halt_req_in_halt", {31'd0, o_halt_req}, 32'd1);
            if (o_out_valid && first_v < 0) first_v = c;
            if (o_done) begin
                seen   = 1'b1;
                done_c = c;
            end
            tick();
            i_start = 1'b0;
            if (!full) i_out_ready = 1'($urandom_range(0, 1));
            if (poke && c == 3) begin
                i_start      = 1'b1;
                i_first_addr = 5'd0;
                i_last_addr  = 5'd31;
            end
            c++;
        end
        i_out_ready = 1'b1;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("first_valid_cycle", first_v, 32'd3);
        if (full) check("done_cycle", done_c, 2 + 2 * n);
        @(negedge clk);
        check("done_one_cycle", {31'd0, o_done}, 32'd0);
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        check("idle_halt_req", {31'd0, o_halt_req}, 32'd0);
        check("idle_rf_addr", {27'd0, o_rf_addr}, 32'd0);
        check("word_count", n_words - w0, n);
        check("sb_empty", sb.size(), 32'd0);
        sb.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int w0;
        exp_t e;
        bit done_hit;

        vecs[0] = '{first: 5'd5,  last: 5'd7,  n: 3,  full: 1'b1, poke: 1'b0};
        vecs[1] = '{first: 5'd30, last: 5'd1,  n: 4,  full: 1'b1, poke: 1'b0};
        vecs[2] = '{first: 5'd12, last: 5'd12, n: 1,  full: 1'b1, poke: 1'b0};
        vecs[3] = '{first: 5'd0,  last: 5'd3,  n: 4,  full: 1'b0, poke: 1'b0};
        vecs[4] = '{first: 5'd31, last: 5'd31, n: 1,  full: 1'b1, poke: 1'b0};
        vecs[5] = '{first: 5'd3,  last: 5'd6,  n: 4,  full: 1'b1, poke: 1'b1};
        vecs[6] = '{first: 5'd20, last: 5'd19, n: 32, full: 1'b0, poke: 1'b0};

        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h10;
        regs[5] = 32'h55;
        regs[6] = 32'h66;
        regs[7] = 32'h77;

        // Reset overrides start and abort
        rst          = 1'b1;
        i_start      = 1'b1;
        i_abort      = 1'b1;
        i_first_addr = 5'd9;
        i_last_addr  = 5'd9;
        i_out_ready  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", {31'd0, o_out_valid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_halt_req", {31'd0, o_halt_req}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_data", o_out_data, 32'd0);
        check("rst_addr", {27'd0, o_out_addr}, 32'd0);
        check("rst_last", {31'd0, o_out_last}, 32'd0);
        check("rst_rf_addr", {27'd0, o_rf_addr}, 32'd0);
        tick();
        rst     = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;

        // start with abort in idle is dropped
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        @(negedge clk);
        check("start_abort_ignored", {31'd0, o_busy}, 32'd0);
        tick();

        // Table-driven dumps
        for (int i = 0; i < 7; i++) begin
            i_out_ready = 1'b1;
            push_range(vecs[i].first, vecs[i].last);
            start_dump(vecs[i].first, vecs[i].last);
            wait_done(vecs[i].n, vecs[i].full, vecs[i].poke);
            tick();
        end

        // Single word with the sink stalled for 5 cycles
        i_out_ready = 1'b0;
        push_range(5'd12, 5'd12);
        start_dump(5'd12, 5'd12);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, o_out_valid}, 32'd1);
            check("stall_word_data", o_out_data, 32'hC0);
            tick();
        end
        i_out_ready = 1'b1;
        @(negedge clk);
        check("stall_valid_6th", {31'd0, o_out_valid}, 32'd1);
        tick();
        @(negedge clk);
        check("stall_done", {31'd0, o_done}, 32'd1);
        check("stall_sb_empty", sb.size(), 32'd0);
        sb.delete();
        tick();

        // Abort during the second SEND of a 0..31 dump, handshake in same cycle
        i_out_ready = 1'b1;
        e = '{addr: 5'd0, data: regs[0], last: 1'b0};
        sb.push_back(e);
        e = '{addr: 5'd1, data: regs[1], last: 1'b0};
        sb.push_back(e);
        start_dump(5'd0, 5'd31);
        tick();
        tick();
        tick();
        tick();
        i_abort = 1'b1;
        @(negedge clk);
        check("abort_in_send", {31'd0, o_out_valid}, 32'd1);
        tick();
        i_abort = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'd0, o_out_valid}, 32'd0);
        check("abort_halt_req", {31'd0, o_halt_req}, 32'd0);
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        done_hit = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            if (o_done || o_out_valid) done_hit = 1'b1;
        end
        check("abort_no_done", {31'd0, done_hit}, 32'd0);
        check("abort_sb_empty", sb.size(), 32'd0);
        sb.delete();
        tick();
        push_range(5'd5, 5'd7);
        start_dump(5'd5, 5'd7);
        wait_done(3, 1'b1, 1'b0);
        tick();

        // Reset during READ discards the dump
        w0 = n_words;
        start_dump(5'd3, 5'd4);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_read_valid", {31'd0, o_out_valid}, 32'd0);
        check("rst_read_halt", {31'd0, o_halt_req}, 32'd0);
        check("rst_read_busy", {31'd0, o_busy}, 32'd0);
        check("rst_read_data", o_out_data, 32'd0);
        check("rst_read_rf_addr", {27'd0, o_rf_addr}, 32'd0);
        rst = 1'b0;
        done_hit = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            if (o_done || o_out_valid) done_hit = 1'b1;
        end
        check("rst_read_no_done", {31'd0, done_hit}, 32'd0);
        check("rst_read_no_words", n_words - w0, 32'd0);
        tick();

        // Core write to x9 on the negedge just before the start edge
        e = '{addr: 5'd9, data: 32'hDEAD, last: 1'b1};
        sb.push_back(e);
        i_first_addr = 5'd9;
        i_last_addr  = 5'd9;
        i_start      = 1'b1;
        @(negedge clk);
        regs[9] = 32'hDEAD;
        tick();
        i_start = 1'b0;
        wait_done(1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
